elevator_car_scheduler: RTL and testbench

Per-car request scheduler and motion sequencer. Merges car-panel floor requests (write strobe plus floor code) and hall calls into a pending-request vector. Runs a collective-selective (SCAN) policy: continue in the current direction while requests lie ahead, stop at every pending floor, otherwise reverse or idle. Drives the motor and door commands and returns the pending vector for button lamps.

---
 rtl/elevator_car_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_elevator_car_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/elevator_car_scheduler.sv
// Per-car SCAN scheduler: merges car-panel and hall requests into a pending
// vector, sequences motor travel floor by floor and holds the door at each stop.
module elevator_car_scheduler #(
  parameter int NUM_FLOORS       = 7,
  parameter int FLOOR_W          = 3,
  parameter int TRAVEL_CYCLES    = 4,
  parameter int DOOR_OPEN_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  car_req_wr_n,
  input  logic [FLOOR_W-1:0]    car_req_floor,
  input  logic [NUM_FLOORS-1:0] hall_call,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  motor_up,
  output logic                  motor_dn,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_DOOR = 2'd2;

  localparam int TC_W = $clog2(TRAVEL_CYCLES + 1);
  localparam int DC_W = $clog2(DOOR_OPEN_CYCLES + 1);

  localparam logic [TC_W-1:0]    TRAVEL_RELOAD = TC_W'(TRAVEL_CYCLES - 1);
  localparam logic [DC_W-1:0]    DOOR_LOAD     = DC_W'(DOOR_OPEN_CYCLES - 1);
  localparam logic [DC_W-1:0]    DOOR_HOLD     = DC_W'(DOOR_OPEN_CYCLES);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR     = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [NUM_FLOORS-1:0] NO_FLOORS  = {NUM_FLOORS{1'b0}};

  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] v;
    v = {NUM_FLOORS{1'b0}};
    for (int i = 0; i < NUM_FLOORS; i++) begin
      v[i] = (int'(f) == i);
    end
    return v;
  endfunction

  logic [1:0]            r_state;
  logic [FLOOR_W-1:0]    r_floor;
  logic                  r_dir_up;
  logic                  r_motor_up;
  logic                  r_motor_dn;
  logic                  r_door_open;
  logic                  r_busy;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [TC_W-1:0]       r_travel_cnt;
  logic [DC_W-1:0]       r_door_cnt;

  logic [NUM_FLOORS-1:0] w_req_vec;
  logic [NUM_FLOORS-1:0] w_set_vec;
  logic [NUM_FLOORS-1:0] w_hold_vec;
  logic [NUM_FLOORS-1:0] w_clear_vec;
  logic                  w_above;
  logic                  w_below;
  logic [FLOOR_W-1:0]    w_step_floor;
  logic                  w_at_limit;
  logic                  w_enter_door;
  logic [FLOOR_W-1:0]    w_door_floor;
  logic [1:0]            w_state_nxt;
  logic [FLOOR_W-1:0]    w_floor_nxt;
  logic                  w_dir_nxt;
  logic                  w_mup_nxt;
  logic                  w_mdn_nxt;
  logic                  w_door_nxt;
  logic [TC_W-1:0]       w_tcnt_nxt;
  logic [DC_W-1:0]       w_dcnt_nxt;

  // Out-of-range floor codes from the car panel are dropped here
  always_comb begin
    w_req_vec = NO_FLOORS;
    if (!car_req_wr_n && (int'(car_req_floor) < NUM_FLOORS)) begin
      w_req_vec = floor_onehot(car_req_floor);
    end else begin
      w_req_vec = NO_FLOORS;
    end
    w_set_vec = hall_call | w_req_vec;
  end

  always_comb begin
    w_above = 1'b0;
    w_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      w_above = w_above | (r_pending[i] & (i > int'(r_floor)));
      w_below = w_below | (r_pending[i] & (i < int'(r_floor)));
    end
  end

  assign w_step_floor = r_dir_up ? (r_floor + FLOOR_W'(1)) : (r_floor - FLOOR_W'(1));
  assign w_at_limit   = r_dir_up ? (r_floor == TOP_FLOOR) : (r_floor == FLOOR_W'(0));

  always_comb begin
    w_state_nxt  = r_state;
    w_floor_nxt  = r_floor;
    w_dir_nxt    = r_dir_up;
    w_mup_nxt    = r_motor_up;
    w_mdn_nxt    = r_motor_dn;
    w_door_nxt   = r_door_open;
    w_tcnt_nxt   = r_travel_cnt;
    w_dcnt_nxt   = r_door_cnt;
    w_enter_door = 1'b0;
    w_door_floor = r_floor;
    w_hold_vec   = NO_FLOORS;
    w_clear_vec  = NO_FLOORS;

    case (r_state)
      S_IDLE: begin
        if (r_pending[r_floor]) begin
          w_enter_door = 1'b1;
        end else if (w_above && w_below) begin
          w_state_nxt = S_MOVE;
          w_mup_nxt   = r_dir_up;
          w_mdn_nxt   = ~r_dir_up;
          w_tcnt_nxt  = TRAVEL_RELOAD;
        end else if (w_above) begin
          w_state_nxt = S_MOVE;
          w_dir_nxt   = 1'b1;
          w_mup_nxt   = 1'b1;
          w_mdn_nxt   = 1'b0;
          w_tcnt_nxt  = TRAVEL_RELOAD;
        end else if (w_below) begin
          w_state_nxt = S_MOVE;
          w_dir_nxt   = 1'b0;
          w_mup_nxt   = 1'b0;
          w_mdn_nxt   = 1'b1;
          w_tcnt_nxt  = TRAVEL_RELOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MOVE: begin
        if (r_travel_cnt != TC_W'(0)) begin
          w_tcnt_nxt = r_travel_cnt - TC_W'(1);
        end else if (w_at_limit) begin
          // Never drive past the shaft ends, even if pending is inconsistent
          w_state_nxt = S_IDLE;
          w_mup_nxt   = 1'b0;
          w_mdn_nxt   = 1'b0;
        end else begin
          w_floor_nxt = w_step_floor;
          if (r_pending[w_step_floor]) begin
            w_enter_door = 1'b1;
            w_door_floor = w_step_floor;
          end else begin
            w_tcnt_nxt = TRAVEL_RELOAD;
          end
        end
      end
      S_DOOR: begin
        if (w_set_vec[r_floor]) begin
          w_hold_vec = floor_onehot(r_floor);
          w_dcnt_nxt = DOOR_HOLD;
        end else if (r_door_cnt != DC_W'(0)) begin
          w_dcnt_nxt = r_door_cnt - DC_W'(1);
        end else begin
          w_state_nxt = S_IDLE;
          w_door_nxt  = 1'b0;
          w_mup_nxt   = 1'b0;
          w_mdn_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_mup_nxt   = 1'b0;
        w_mdn_nxt   = 1'b0;
        w_door_nxt  = 1'b0;
        w_tcnt_nxt  = TC_W'(0);
        w_dcnt_nxt  = DC_W'(0);
      end
    endcase

    // A same-cycle request for the served floor extends the door instead of latching
    if (w_enter_door) begin
      w_state_nxt = S_DOOR;
      w_mup_nxt   = 1'b0;
      w_mdn_nxt   = 1'b0;
      w_door_nxt  = 1'b1;
      w_clear_vec = floor_onehot(w_door_floor);
      w_dcnt_nxt  = w_set_vec[w_door_floor] ? DOOR_HOLD : DOOR_LOAD;
    end else begin
      w_clear_vec = NO_FLOORS;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_floor      <= FLOOR_W'(0);
      r_dir_up     <= 1'b1;
      r_motor_up   <= 1'b0;
      r_motor_dn   <= 1'b0;
      r_door_open  <= 1'b0;
      r_busy       <= 1'b0;
      r_pending    <= NO_FLOORS;
      r_travel_cnt <= TC_W'(0);
      r_door_cnt   <= DC_W'(0);
    end else begin
      r_state      <= w_state_nxt;
      r_floor      <= w_floor_nxt;
      r_dir_up     <= w_dir_nxt;
      r_motor_up   <= w_mup_nxt;
      r_motor_dn   <= w_mdn_nxt;
      r_door_open  <= w_door_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_pending    <= (r_pending | (w_set_vec & ~w_hold_vec)) & ~w_clear_vec;
      r_travel_cnt <= w_tcnt_nxt;
      r_door_cnt   <= w_dcnt_nxt;
    end
  end

  assign current_floor = r_floor;
  assign motor_up      = r_motor_up;
  assign motor_dn      = r_motor_dn;
  assign door_open     = r_door_open;
  assign pending       = r_pending;
  assign dir_up        = r_dir_up;
  assign busy          = r_busy;

endmodule

// File: tb/tb_elevator_car_scheduler.sv
// Directed bench for elevator_car_scheduler: cycle-exact hand-computed
// expectations for reset, travel, door hold-open, reversal and invalid codes.
module tb_elevator_car_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       car_req_wr_n = 1'b1;
  logic [2:0] car_req_floor = 3'd0;
  logic [6:0] hall_call = 7'd0;
  logic [2:0] current_floor;
  logic       motor_up;
  logic       motor_dn;
  logic       door_open;
  logic [6:0] pending;
  logic       dir_up;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  elevator_car_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .car_req_wr_n  (car_req_wr_n),
    .car_req_floor (car_req_floor),
    .hall_call     (hall_call),
    .current_floor (current_floor),
    .motor_up      (motor_up),
    .motor_dn      (motor_dn),
    .door_open     (door_open),
    .pending       (pending),
    .dir_up        (dir_up),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    car_req_wr_n = 1'b1;
    hall_call = 7'd0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  // One-cycle car-panel write; returns 1 ns after the capturing edge
  task automatic req_car(input logic [2:0] f);
    car_req_floor = f;
    car_req_wr_n = 1'b0;
    tick(1);
    car_req_wr_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_floor", 32'(current_floor), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_dir", 32'(dir_up), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_motors", 32'({motor_up, motor_dn, door_open}), 32'd0);

    // Test 1: asynchronous reset while climbing past floor 2
    req_car(3'd5);
    tick(1);
    tick(8);
    chk("t1_floor2", 32'(current_floor), 32'd2);
    chk("t1_moving", 32'(motor_up), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t1_async_floor", 32'(current_floor), 32'd0);
    chk("t1_async_outs", 32'({motor_up, motor_dn, door_open, busy}), 32'd0);
    chk("t1_async_pend", 32'(pending), 32'd0);
    chk("t1_async_dir", 32'(dir_up), 32'd1);
    tick(1);
    reset = 1'b0;
    tick(3);
    chk("t1_idle", 32'({busy, motor_up, motor_dn}), 32'd0);

    // Test 2: request floor 3 from floor 0
    req_car(3'd3);
    chk("t2_pend_n1", 32'(pending), 32'h08);
    chk("t2_motor_n1", 32'(motor_up), 32'd0);
    tick(1);
    chk("t2_motor_n2", 32'(motor_up), 32'd1);
    chk("t2_busy", 32'(busy), 32'd1);
    tick(3);
    chk("t2_still0", 32'(current_floor), 32'd0);
    tick(1);
    chk("t2_floor1", 32'(current_floor), 32'd1);
    tick(4);
    chk("t2_floor2", 32'(current_floor), 32'd2);
    tick(4);
    chk("t2_floor3", 32'(current_floor), 32'd3);
    chk("t2_stop", 32'({motor_up, motor_dn, door_open}), 32'b001);
    chk("t2_pend_clr", 32'(pending), 32'd0);
    tick(7);
    chk("t2_door_last", 32'(door_open), 32'd1);
    tick(1);
    chk("t2_door_closed", 32'({door_open, busy}), 32'd0);

    // Test 3: request own floor, then hold-open during door cycle 5
    do_reset();
    req_car(3'd0);
    tick(1);
    chk("t3_door", 32'(door_open), 32'd1);
    chk("t3_pend0", 32'(pending), 32'd0);
    chk("t3_nomotor", 32'({motor_up, motor_dn}), 32'd0);
    tick(4);
    req_car(3'd0);
    chk("t3_hold_pend", 32'(pending), 32'd0);
    tick(8);
    chk("t3_held", 32'(door_open), 32'd1);
    tick(1);
    chk("t3_closed", 32'(door_open), 32'd0);

    // Test 4: collect 4 and 5 going up, then reverse to 1
    do_reset();
    req_car(3'd5);
    tick(1);
    tick(8);
    chk("t4_at2", 32'(current_floor), 32'd2);
    car_req_floor = 3'd1;
    car_req_wr_n = 1'b0;
    hall_call = 7'h10;
    tick(1);
    car_req_wr_n = 1'b1;
    hall_call = 7'h00;
    chk("t4_pend", 32'(pending), 32'h32);
    tick(3);
    chk("t4_pass3", 32'({current_floor, motor_up, door_open}), 32'({3'd3, 1'b1, 1'b0}));
    tick(4);
    chk("t4_stop4", 32'({current_floor, motor_up, door_open}), 32'({3'd4, 1'b0, 1'b1}));
    chk("t4_pend4", 32'(pending), 32'h22);
    tick(8);
    chk("t4_door4_done", 32'(door_open), 32'd0);
    tick(1);
    chk("t4_resume_up", 32'({motor_up, dir_up}), 32'b11);
    tick(4);
    chk("t4_stop5", 32'({current_floor, door_open}), 32'({3'd5, 1'b1}));
    chk("t4_pend5", 32'(pending), 32'h02);
    tick(8);
    chk("t4_idle5", 32'({busy, door_open}), 32'd0);
    tick(1);
    chk("t4_reverse", 32'({motor_up, motor_dn, dir_up}), 32'b010);
    tick(16);
    chk("t4_stop1", 32'({current_floor, door_open}), 32'({3'd1, 1'b1}));
    chk("t4_pend_end", 32'(pending), 32'd0);
    tick(8);
    chk("t4_idle1", 32'(busy), 32'd0);

    // Test 5: out-of-range floor code is ignored
    req_car(3'd7);
    chk("t5_pend", 32'(pending), 32'd0);
    tick(1);
    chk("t5_idle", 32'({busy, motor_up, motor_dn}), 32'd0);
    chk("t5_floor", 32'(current_floor), 32'd1);

    // Test 6: park at 3 heading down, then calls at 0 and 6
    do_reset();
    req_car(3'd4);
    tick(17);
    chk("t6_at4", 32'({current_floor, door_open}), 32'({3'd4, 1'b1}));
    tick(8);
    chk("t6_idle4", 32'(busy), 32'd0);
    req_car(3'd3);
    chk("t6_pend3", 32'(pending), 32'h08);
    tick(1);
    chk("t6_down", 32'({motor_dn, dir_up}), 32'b10);
    tick(4);
    chk("t6_at3", 32'({current_floor, door_open}), 32'({3'd3, 1'b1}));
    tick(8);
    chk("t6_idle3", 32'({busy, dir_up}), 32'd0);
    hall_call = 7'h41;
    tick(1);
    hall_call = 7'h00;
    chk("t6_pend41", 32'(pending), 32'h41);
    tick(1);
    chk("t6_keep_down", 32'({motor_up, motor_dn, dir_up}), 32'b010);
    tick(12);
    chk("t6_at0", 32'({current_floor, door_open}), 32'({3'd0, 1'b1}));
    chk("t6_pend40", 32'(pending), 32'h40);
    tick(8);
    chk("t6_door0_done", 32'(door_open), 32'd0);
    tick(1);
    chk("t6_up", 32'({motor_up, motor_dn, dir_up}), 32'b101);
    tick(24);
    chk("t6_at6", 32'({current_floor, door_open, motor_up}), 32'({3'd6, 1'b1, 1'b0}));
    chk("t6_pend_end", 32'(pending), 32'd0);
    tick(8);
    chk("t6_idle6", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
